multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore-style FSM that sequences the multi-cycle RV32 datapath. It covers R-type (0110011), load (0000011), store (0100011) and branch (1100011).
It replaces single-cycle decode with per-state control of PC, IR, register file, ALU muxes and a shared instruction/data memory that uses a ready handshake.
It sits between the instruction register's opcode field and all datapath enables/selects. It traps on illegal opcodes and memory timeouts.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles a memory state waits with mem_ready=0 before trapping (1..2^CNT_W-1)
CNT_W, 4, width of the wait counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0]; stable from DECODE until the instruction returns to FETCH
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  PC load enable
ir_write  output  1  IR load enable
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  address select: 0=PC, 1=ALUOut
mem_to_reg  output  1  writeback select: 0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
alu_src_a  output  2  00=PC, 01=rs1
alu_src_b  output  2  00=rs2, 01=const 4, 10=imm
alu_op  output  2  00=add, 01=sub/compare, 10=funct-decoded
pc_src  output  1  0=ALU result, 1=ALUOut (branch target)
state  output  4  current state encoding (debug)
illegal  output  1  high while in TRAP
trap_cause  output  1  0=illegal opcode, 1=memory timeout; valid while illegal=1

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, ALU_WB=7, BRANCH=8, TRAP=9. Unused codes go to FETCH on the next edge.
- Reset (async): state=FETCH, wait_cnt=0, trap_cause=0.
  - While reset=1, every enable/request output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced 0.
  - While reset=1, selects are 0, state=0 and illegal=0.
  - Reset mid-instruction aborts it with no write issued.
- Outputs are combinational from state (plus mem_ready/zero where noted). Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - 0110011 -> EXEC_R; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH.
  - Any other opcode -> TRAP with trap_cause=0.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1. mem_ready -> FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero -> FETCH.
- TRAP: illegal=1, all enables 0. Held until reset; trap_cause is held.
- Wait counter (FETCH, MEM_READ, MEM_WRITE only):
  - wait_cnt clears on entry to any state and increments each cycle mem_ready=0.
  - If wait_cnt==WAIT_LIMIT and mem_ready=0 -> TRAP with trap_cause=1.
  - Max cycles in a memory state = WAIT_LIMIT+1.
  - mem_ready=1 on the limit cycle completes normally (ready wins).
  - Counter saturates and never wraps.
- Latency with zero-wait memory:
  - R-type 4 cycles, load 5, store 4, branch 3.
  - Each memory wait cycle adds 1.

Test Plan:
- R-type 0110011, mem_ready=1 always -> states 0,1,6,7,0. ir_write/pc_write=1 in FETCH only; reg_write=1 only in state 7 with mem_to_reg=0.
- Load 0000011, read returns mem_ready after 3 low cycles -> MEM_READ lasts 4 cycles with iord=1, mem_read=1. Then MEM_WB shows reg_write=1, mem_to_reg=1. Total 8 cycles.
- Branch 1100011: with zero=1, pc_write=1 and pc_src=1 in state 8. With zero=0, pc_write=0. Both return to FETCH after 3 cycles.
- Store 0100011 -> mem_write=1 for exactly one cycle with mem_ready=1; reg_write never asserts.
- Illegal opcode 0010011 -> TRAP (state=9), illegal=1, trap_cause=0. Stays with all enables 0 for 20 cycles; reset returns to FETCH.
- Timeout and reset:
  - mem_ready held 0 in FETCH, WAIT_LIMIT=15 -> TRAP after 16 cycles with trap_cause=1.
  - Reset asserted mid-MEM_WRITE -> mem_write drops in the same cycle; state=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Bundles the signals between the multi-cycle RV32 controller and its datapath.
//
//   Datapath -> controller
//     opcode[6:0]     IR[6:0]; held stable from DECODE until the next FETCH
//     zero            ALU zero flag
//     mem_ready       shared memory completes the current read/write this cycle
//   Controller -> datapath
//     pc_write        PC load enable
//     ir_write        IR load enable
//     mem_read        memory read request
//     mem_write       memory write request
//     iord            address select: 0=PC, 1=ALUOut
//     mem_to_reg      writeback select: 0=ALUOut, 1=MDR
//     reg_write       register file write enable
//     alu_src_a[1:0]  00=PC, 01=rs1
//     alu_src_b[1:0]  00=rs2, 01=const 4, 10=imm
//     alu_op[1:0]     00=add, 01=sub/compare, 10=funct-decoded
//     pc_src          0=ALU result, 1=ALUOut (branch target)
//     state[3:0]      current controller state (debug)
//     illegal         high while trapped
//     trap_cause      0=illegal opcode, 1=memory timeout; valid while illegal=1
//
// The controller uses the master modport; the datapath (or a testbench acting
// as one) uses the slave modport.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;

  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_src;
  logic [3:0] state;
  logic       illegal;
  logic       trap_cause;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, iord, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state,
           illegal, trap_cause
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, iord, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state,
           illegal, trap_cause
  );

endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a multi-cycle RV32 datapath with a shared
// instruction/data memory using a ready handshake. Supports R-type, load,
// store and branch; anything else traps. Each memory state (FETCH, MEM_READ,
// MEM_WRITE) may wait at most WAIT_LIMIT+1 cycles for mem_ready before the
// controller traps with a timeout cause.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; while high all outputs are forced to 0
//   bus    multicycle_controller_if.master (opcode/zero/mem_ready in,
//          datapath enables/selects, debug state and trap status out)
//
// Parameters
//   WAIT_LIMIT  max wait_cnt value tolerated with mem_ready=0 (1..2^CNT_W-1)
//   CNT_W       width of the wait counter
//
// Zero-wait latencies: R-type 4, load 5, store 4, branch 3 cycles; each
// memory wait cycle adds one.
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  // State encoding is visible on the debug port, so the codes are fixed.
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_TRAP      = 4'd9;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Datapath select encodings
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  logic [3:0]       state_q,      state_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             trap_cause_q, trap_cause_d;

  logic mem_state;   // current state waits on the memory handshake
  logic timeout;     // wait budget exhausted and memory still not ready

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    trap_cause_d = trap_cause_q;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                (state_q == S_MEM_WRITE);
    // ready on the limit cycle still completes normally
    timeout   = mem_state && !bus.mem_ready && (wait_cnt_q == CNT_LIMIT);

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end

      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:           state_d = S_EXEC_R;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = 1'b0;
          end
        endcase
      end

      // Opcode is held stable, so only load vs. store needs distinguishing.
      S_MEM_ADDR: state_d = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;

      S_MEM_READ: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end

      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end

      S_MEM_WB:  state_d = S_FETCH;
      S_EXEC_R:  state_d = S_ALU_WB;
      S_ALU_WB:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;    // only reset leaves TRAP
      default:   state_d = S_FETCH;   // recover from unused encodings
    endcase

    // The counter only grows while a memory state keeps waiting; any state
    // change (including into TRAP) restarts it from zero. Saturation keeps a
    // CNT_LIMIT of all-ones from wrapping back to zero.
    if (mem_state && (state_d == state_q)) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs (mem_ready gates the FETCH writes, zero gates the branch)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = 1'b0;
    bus.state      = 4'd0;
    bus.illegal    = 1'b0;
    bus.trap_cause = 1'b0;

    // Reset is asynchronous, so the outputs are gated directly rather than
    // relying on state_q: FETCH itself would otherwise request a read while
    // reset is still asserted.
    if (!reset) begin
      bus.state      = state_q;
      bus.trap_cause = trap_cause_q;

      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.iord      = 1'b0;
          bus.alu_src_a = SRC_A_PC;
          bus.alu_src_b = SRC_B_FOUR;
          bus.alu_op    = ALU_ADD;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end

        // PC + imm lands in ALUOut as the speculative branch target.
        S_DECODE: begin
          bus.alu_src_a = SRC_A_PC;
          bus.alu_src_b = SRC_B_IMM;
          bus.alu_op    = ALU_ADD;
        end

        S_MEM_ADDR: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
          bus.alu_op    = ALU_ADD;
        end

        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end

        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end

        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end

        S_EXEC_R: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_RS2;
          bus.alu_op    = ALU_FUNCT;
        end

        S_ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b0;
        end

        // rs1 - rs2 sets zero; PC takes the target held in ALUOut only if equal.
        S_BRANCH: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_RS2;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = 1'b1;
          bus.pc_write  = bus.zero;
        end

        S_TRAP: bus.illegal = 1'b1;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into the list of states it must visit (derived from its class and the number
// of memory wait cycles), the memory handshake is driven from that list, and
// every cycle the debug state and all control outputs are compared against a
// per-state output table. Directed cases come first, then random instructions.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int LIMIT = 15;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2,
                         MEM_READ = 4'd3, MEM_WB = 4'd4, MEM_WRITE = 4'd5,
                         EXEC_R = 4'd6, ALU_WB = 4'd7, BRANCH = 4'd8,
                         TRAP = 4'd9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011,
                         OP_ILL = 7'b0010011;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       illegal;
    logic       trap_cause;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic       ready;   // handshake value to drive in memory states
    logic       cause;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  step_t plan[$];

  multicycle_controller_if bus ();

  multicycle_controller #(.WAIT_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output table: what each state must drive.
  function automatic ctl_t expect_ctl(logic [3:0] st, logic ready, logic z,
                                      logic cause);
    ctl_t c = '0;
    case (st)
      FETCH:     begin c.mem_read = 1; c.src_b = 2'b01;
                       c.ir_write = ready; c.pc_write = ready; end
      DECODE:    c.src_b = 2'b10;
      MEM_ADDR:  begin c.src_a = 2'b01; c.src_b = 2'b10; end
      MEM_READ:  begin c.mem_read = 1; c.iord = 1; end
      MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
      MEM_WRITE: begin c.mem_write = 1; c.iord = 1; end
      EXEC_R:    begin c.src_a = 2'b01; c.alu_op = 2'b10; end
      ALU_WB:    c.reg_write = 1;
      BRANCH:    begin c.src_a = 2'b01; c.alu_op = 2'b01; c.pc_src = 1;
                       c.pc_write = z; end
      TRAP:      begin c.illegal = 1; c.trap_cause = cause; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.ir_write   = bus.ir_write;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.iord       = bus.iord;
    c.mem_to_reg = bus.mem_to_reg;
    c.reg_write  = bus.reg_write;
    c.src_a      = bus.alu_src_a;
    c.src_b      = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.pc_src     = bus.pc_src;
    c.illegal    = bus.illegal;
    c.trap_cause = bus.trap_cause;
    return c;
  endfunction

  task automatic check_now(string tag, logic [3:0] exp_st, ctl_t exp_c);
    ctl_t got;
    got = observed();
    checks++;
    assert (bus.state === exp_st) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state, exp_st);
    end
    checks++;
    assert (got === exp_c) else begin
      errors++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, got, exp_c);
    end
  endtask

  // Called just after a falling edge; holds reset for one full cycle.
  task automatic do_reset(string tag);
    reset         = 1'b1;
    bus.mem_ready = 1'($urandom);
    bus.zero      = 1'($urandom);
    #1 check_now({tag, "_rst_a"}, 4'd0, '0);
    @(negedge clk);
    #1 check_now({tag, "_rst_b"}, 4'd0, '0);
    reset = 1'b0;
  endtask

  // A memory phase with `waits` not-ready cycles. More than LIMIT waits means
  // LIMIT+1 not-ready cycles and then a timeout.
  task automatic add_mem(logic [3:0] st, int waits, output bit trapped);
    for (int i = 0; i < waits && i <= LIMIT; i++) plan.push_back('{st, 1'b0, 1'b0});
    trapped = (waits > LIMIT);
    if (!trapped) plan.push_back('{st, 1'b1, 1'b0});
  endtask

  // Expands one instruction into its expected state list and plays it.
  // abort_at >= 0 asserts reset in the middle of that step.
  task automatic run_instr(string tag, logic [6:0] op, int fw, int mw,
                           int zero_force, int abort_at, int hold);
    bit   trapped;
    logic cause;
    logic r, z;
    plan.delete();
    cause = 1'b1;
    add_mem(FETCH, fw, trapped);
    if (!trapped) begin
      plan.push_back('{DECODE, 1'b0, 1'b0});
      case (op)
        OP_R:  begin plan.push_back('{EXEC_R, 1'b0, 1'b0});
                     plan.push_back('{ALU_WB, 1'b0, 1'b0}); end
        OP_LD: begin plan.push_back('{MEM_ADDR, 1'b0, 1'b0});
                     add_mem(MEM_READ, mw, trapped);
                     if (!trapped) plan.push_back('{MEM_WB, 1'b0, 1'b0}); end
        OP_ST: begin plan.push_back('{MEM_ADDR, 1'b0, 1'b0});
                     add_mem(MEM_WRITE, mw, trapped); end
        OP_BR: plan.push_back('{BRANCH, 1'b0, 1'b0});
        default: begin trapped = 1'b1; cause = 1'b0; end
      endcase
    end
    if (trapped) for (int i = 0; i < hold; i++) plan.push_back('{TRAP, 1'b0, cause});

    bus.opcode = op;
    foreach (plan[i]) begin
      if (plan[i].st == FETCH || plan[i].st == MEM_READ || plan[i].st == MEM_WRITE)
        r = plan[i].ready;
      else
        r = 1'($urandom);
      z = (zero_force >= 0) ? 1'(zero_force) : 1'($urandom);
      bus.mem_ready = r;
      bus.zero      = z;
      #1 check_now($sformatf("%s_c%0d", tag, i), plan[i].st,
                   expect_ctl(plan[i].st, r, z, plan[i].cause));
      if (i == abort_at) begin
        #2 reset = 1'b1;
        #1 check_now({tag, "_abort"}, 4'd0, '0);
        @(negedge clk);
        do_reset(tag);
        return;
      end
      @(negedge clk);
    end
    if (trapped) do_reset(tag);
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    case ($urandom_range(0, 4))
      0: o = OP_R;
      1: o = OP_LD;
      2: o = OP_ST;
      3: o = OP_BR;
      default: begin
        o = 7'($urandom);
        if (o == OP_R || o == OP_LD || o == OP_ST || o == OP_BR) o = OP_ILL;
      end
    endcase
    return o;
  endfunction

  function automatic int rand_wait();
    int k = $urandom_range(0, 9);
    if (k == 0) return LIMIT;
    if (k == 1) return LIMIT + 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bus.opcode    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    reset         = 1'b1;
    do_reset("init");

    // Directed cases
    run_instr("rtype",     OP_R,   0, 0,  -1, -1, 0);
    run_instr("load_w3",   OP_LD,  0, 3,  -1, -1, 0);
    run_instr("br_taken",  OP_BR,  0, 0,   1, -1, 0);
    run_instr("br_not",    OP_BR,  0, 0,   0, -1, 0);
    run_instr("store",     OP_ST,  0, 0,  -1, -1, 0);
    run_instr("illegal",   OP_ILL, 0, 0,  -1, -1, 20);
    run_instr("fetch_to",  OP_R,   LIMIT + 1, 0, -1, -1, 3);
    run_instr("fetch_lim", OP_R,   LIMIT, 0, -1, -1, 0);
    run_instr("ld_to",     OP_LD,  1, LIMIT + 1, -1, -1, 2);
    run_instr("st_lim",    OP_ST,  0, LIMIT, -1, -1, 0);
    run_instr("st_abort",  OP_ST,  0, 3,  -1, 3, 0);
    run_instr("after_rst", OP_BR,  2, 0,   1, -1, 0);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      int fw, mw, ab;
      op = rand_op();
      fw = rand_wait();
      mw = rand_wait();
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1;
      run_instr($sformatf("rnd%0d", n), op, fw, mw, -1, ab, $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
